ufm_arbiter: RTL and testbench
==============================

Name: ufm_arbiter

Overview:
- Arbitrates the single UFM Avalon-MM data port between two Avalon-MM masters.
  - m0: serial-load writer.
  - m1: register-loading reader.
- Replaces the controlstate-based address/burstcount muxing at top level.
- Locks the grant for a whole transaction: one single-beat write, or one read burst until its last readdatavalid.
- Sits between the UFM write/read sequencers and the ufm IP data port, all on clk.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 32, data width.
- BURST_W, 5, burstcount width.
- MAX_BURST, 8, largest legal read burst.

Ports:
- clk  in  1  system clock (25 MHz domain).
- reset  in  1  synchronous, active-high reset.
- mN_read / mN_write  in  1  master N request, N=0,1.
- mN_addr  in  ADDR_W  master N address.
- mN_writedata  in  DATA_W  master N write data.
- mN_burstcount  in  BURST_W  master N burst length.
- mN_waitrequest  out  1  stall to master N.
- mN_readdata  out  DATA_W  read data to master N.
- mN_readdatavalid  out  1  read beat valid to master N.
- s_read / s_write  out  1  to UFM.
- s_addr  out  ADDR_W  to UFM.
- s_writedata  out  DATA_W  to UFM.
- s_burstcount  out  BURST_W  to UFM.
- s_waitrequest  in  1  from UFM.
- s_readdata  in  DATA_W  from UFM.
- s_readdatavalid  in  1  from UFM.
- owner  out  1  current/last grantee.
- busy  out  1  transaction in progress.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset values:
  - state=IDLE, owner=0, busy=0, err=0, beat counter=0.
  - s_read=s_write=0; both mN_waitrequest=1; both mN_readdatavalid=0.
- Legal requests:
  - write with burstcount==1;
  - read with 1<=burstcount<=MAX_BURST;
  - never read and write asserted together.
- Illegal requests:
  - set err (sticky until reset), are never forwarded, and hold that master's waitrequest=1 while asserted;
  - the other master remains serviceable.
- Requests must be held stable until accepted (Avalon rule); the arbiter does not re-check them.
- IDLE:
  - sample legal requests; pick a winner; register owner and the latched burstcount.
  - Go to CMD next cycle; busy=1 from that cycle.
  - Request-to-s_read/s_write latency is exactly 1 cycle.
- CMD:
  - s_* signals combinationally follow the owner's inputs; mOwner_waitrequest = s_waitrequest; the non-owner sees waitrequest=1.
  - On accept (command && !s_waitrequest):
    - write: go to IDLE next cycle (busy drops);
    - read: go to RDATA with beat counter=0.
- RDATA:
  - s_read=s_write=0.
  - s_readdata and s_readdatavalid are routed to the owner only; the non-owner sees readdatavalid=0.
  - The counter increments per valid beat. On the beat where count==burstcount-1, go to IDLE next cycle.
  - New requests wait until then; back-to-back transactions are IDLE-separated by 1 cycle minimum.
- s_readdatavalid in IDLE or CMD: dropped, sets err.
- mN_readdata is driven by s_readdata at all times; only readdatavalid is gated.
- Fixed priority (default):
  - m0 wins on simultaneous requests;
  - m1 starves while m0 keeps requesting.
- reset during CMD or RDATA:
  - abort immediately to IDLE; outputs return to reset values next cycle;
  - late UFM beats are dropped; err is not set by them, because err was cleared by reset.

Optional Feature:
- UFM_ARB_RR_EN
  - Defined: round-robin arbitration. On simultaneous requests the master that was not the last grantee wins; owner holds the last grantee. A single requester always wins.
  - Undefined: fixed m0 priority as above.

Decomposition:
- Package ufm_arb_pkg holds:
  - state enum: IDLE, CMD, RDATA;
  - localparam widths;
  - function legal_req(read, write, burstcount) returning 1-bit legality.
- One natural sub-module, ufm_arb_sel, containing:
  - winner selection (fixed / RR under the macro);
  - last-grant register.
- The rest stays in ufm_arbiter.

Test Plan:
- m0 write addr 0x0010 data 0xDEADBEEF burst 1, s_waitrequest held 3 cycles -> s_write asserted 1 cycle after request; m0_waitrequest mirrors the stall; busy drops 1 cycle after accept.
- m1 read addr 0x0020 burst 6, UFM returns 6 beats with gaps -> m1_readdatavalid exactly 6 times with matching data; busy=1 until 1 cycle after the 6th beat; m0 sees no valid.
- Simultaneous m0 write and m1 read:
  - without UFM_ARB_RR_EN -> m0 served first, then m1;
  - with UFM_ARB_RR_EN and last grant=m0 -> m1 first.
- m1 read burstcount 0, then 9 -> err=1, no s_read, m1_waitrequest stays 1; a subsequent legal m0 write completes normally.
- reset asserted after beat 3 of a 6-beat read -> next cycle state IDLE, busy=0; beats 4-6 not forwarded; err=0.
- Spurious s_readdatavalid in IDLE -> err=1, no mN_readdatavalid.

Source files
------------

// File: rtl/ufm_arb_pkg.sv
// Shared types and helpers for the UFM data-port arbiter.
// Arbitration policy is selected by UFM_ARB_RR_EN in ufm_arb_sel.
package ufm_arb_pkg;

  localparam int unsigned ADDR_W_DEF    = 16;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned BURST_W_DEF   = 5;
  localparam int unsigned MAX_BURST_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RDATA
  } state_t;

  // Writes are single-beat only; reads may burst up to max_burst.
  function automatic logic legal_req(input logic        read,
                                     input logic        write,
                                     input int unsigned burstcount,
                                     input int unsigned max_burst = MAX_BURST_DEF);
    if (read && write) return 1'b0;
    if (write)         return burstcount == 1;
    if (read)          return (burstcount >= 1) && (burstcount <= max_burst);
    return 1'b0;
  endfunction

endpackage

// File: rtl/ufm_arb_sel.sv
// Winner selection and last-grant register for ufm_arbiter.
// UFM_ARB_RR_EN selects round-robin; otherwise m0 has fixed priority.
module ufm_arb_sel (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic grant,
  output logic winner,
  output logic last
);

  always_comb begin
`ifdef UFM_ARB_RR_EN
    winner = (req0 && req1) ? ~last : req1;
`else
    winner = req1 & ~req0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset)      last <= 1'b0;
    else if (grant) last <= winner;
  end

endmodule

// File: rtl/ufm_arbiter.sv
// Two-master Avalon-MM arbiter for the UFM data port; grant is held for a whole
// write or read burst. Define UFM_ARB_RR_EN for round-robin arbitration.
module ufm_arbiter
  import ufm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BURST_W   = BURST_W_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [ADDR_W-1:0]  m0_addr,
  input  logic [DATA_W-1:0]  m0_writedata,
  input  logic [BURST_W-1:0] m0_burstcount,
  output logic               m0_waitrequest,
  output logic [DATA_W-1:0]  m0_readdata,
  output logic               m0_readdatavalid,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [ADDR_W-1:0]  m1_addr,
  input  logic [DATA_W-1:0]  m1_writedata,
  input  logic [BURST_W-1:0] m1_burstcount,
  output logic               m1_waitrequest,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic               m1_readdatavalid,
  output logic               s_read,
  output logic               s_write,
  output logic [ADDR_W-1:0]  s_addr,
  output logic [DATA_W-1:0]  s_writedata,
  output logic [BURST_W-1:0] s_burstcount,
  input  logic               s_waitrequest,
  input  logic [DATA_W-1:0]  s_readdata,
  input  logic               s_readdatavalid,
  output logic               owner,
  output logic               busy,
  output logic               err
);

  state_t             state, state_nxt;
  logic [BURST_W-1:0] burst, cnt;
  logic               legal0, legal1, illegal, start, winner;

  assign legal0  = legal_req(m0_read, m0_write, 32'(m0_burstcount), MAX_BURST);
  assign legal1  = legal_req(m1_read, m1_write, 32'(m1_burstcount), MAX_BURST);
  assign illegal = ((m0_read | m0_write) & ~legal0) | ((m1_read | m1_write) & ~legal1);
  assign start   = (state == IDLE) && (legal0 || legal1);

  ufm_arb_sel u_sel (
    .clk    (clk),
    .reset  (reset),
    .req0   (legal0),
    .req1   (legal1),
    .grant  (start),
    .winner (winner),
    .last   (owner)
  );

  assign busy        = (state != IDLE);
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

  always_comb begin
    state_nxt        = state;
    s_read           = 1'b0;
    s_write          = 1'b0;
    s_addr           = owner ? m1_addr : m0_addr;
    s_writedata      = owner ? m1_writedata : m0_writedata;
    s_burstcount     = owner ? m1_burstcount : m0_burstcount;
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;
    m0_readdatavalid = 1'b0;
    m1_readdatavalid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CMD;
      end
      CMD: begin
        s_read  = owner ? m1_read : m0_read;
        s_write = owner ? m1_write : m0_write;
        if (owner) m1_waitrequest = s_waitrequest;
        else       m0_waitrequest = s_waitrequest;
        if ((s_read || s_write) && !s_waitrequest)
          state_nxt = s_write ? IDLE : RDATA;
      end
      RDATA: begin
        m0_readdatavalid = s_readdatavalid & ~owner;
        m1_readdatavalid = s_readdatavalid & owner;
        if (s_readdatavalid && (cnt == burst - BURST_W'(1)))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      burst <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start)
        burst <= winner ? m1_burstcount : m0_burstcount;
      if (state == CMD)
        cnt <= '0;
      else if (state == RDATA && s_readdatavalid)
        cnt <= cnt + BURST_W'(1);
      // Beats outside RDATA have no owner to go to; they are dropped and flagged.
      err <= err | illegal | (s_readdatavalid && state != RDATA);
    end
  end

endmodule

// File: tb/tb_ufm_arbiter.sv
// Directed self-checking bench for ufm_arbiter: legality table plus
// hand-written multi-cycle sequences (stall, bursts, arbitration, reset abort).
module tb_ufm_arbiter;

  logic        clk, reset;
  logic        m0_read, m0_write, m0_waitrequest, m0_readdatavalid;
  logic [15:0] m0_addr;
  logic [31:0] m0_writedata, m0_readdata;
  logic [4:0]  m0_burstcount;
  logic        m1_read, m1_write, m1_waitrequest, m1_readdatavalid;
  logic [15:0] m1_addr;
  logic [31:0] m1_writedata, m1_readdata;
  logic [4:0]  m1_burstcount;
  logic        s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [15:0] s_addr;
  logic [31:0] s_writedata, s_readdata;
  logic [4:0]  s_burstcount;
  logic        owner, busy, err;

  int checks = 0;
  int errors = 0;

`ifdef UFM_ARB_RR_EN
  localparam logic FIRST = 1'b1;
`else
  localparam logic FIRST = 1'b0;
`endif

  ufm_arbiter #(.ADDR_W(16), .DATA_W(32), .BURST_W(5), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr),
    .m0_writedata(m0_writedata), .m0_burstcount(m0_burstcount),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr),
    .m1_writedata(m1_writedata), .m1_burstcount(m1_burstcount),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_read(s_read), .s_write(s_write), .s_addr(s_addr),
    .s_writedata(s_writedata), .s_burstcount(s_burstcount),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .owner(owner), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic       rd;
    logic       wr;
    logic [4:0] bc;
    logic       exp_rd;
    logic       exp_wr;
    logic       exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic clear_inputs;
    m0_read = 0; m0_write = 0; m0_addr = '0; m0_writedata = '0; m0_burstcount = '0;
    m1_read = 0; m1_write = 0; m1_addr = '0; m1_writedata = '0; m1_burstcount = '0;
    s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    int nbeats;
    logic who, exp_v;

    vecs[0] = '{"rd_b1",  1, 0, 5'd1, 1, 0, 0};
    vecs[1] = '{"rd_b8",  1, 0, 5'd8, 1, 0, 0};
    vecs[2] = '{"rd_b0",  1, 0, 5'd0, 0, 0, 1};
    vecs[3] = '{"rd_b9",  1, 0, 5'd9, 0, 0, 1};
    vecs[4] = '{"wr_b1",  0, 1, 5'd1, 0, 1, 0};
    vecs[5] = '{"wr_b2",  0, 1, 5'd2, 0, 0, 1};
    vecs[6] = '{"rdwr",   1, 1, 5'd1, 0, 0, 1};

    // Reset state
    do_reset();
    settle();
    chk1("rst_s_read", s_read, 0);
    chk1("rst_s_write", s_write, 0);
    chk1("rst_m0_wait", m0_waitrequest, 1);
    chk1("rst_m1_wait", m1_waitrequest, 1);
    chk1("rst_m0_rdv", m0_readdatavalid, 0);
    chk1("rst_m1_rdv", m1_readdatavalid, 0);
    chk1("rst_owner", owner, 0);
    chk1("rst_busy", busy, 0);
    chk1("rst_err", err, 0);

    // Legality table on m1, UFM stalling so CMD is observable
    for (int i = 0; i < 7; i++) begin
      do_reset();
      m1_read = vecs[i].rd;
      m1_write = vecs[i].wr;
      m1_burstcount = vecs[i].bc;
      m1_addr = 16'h0100 + 16'(i);
      s_waitrequest = 1;
      tick();
      settle();
      chk1({vecs[i].name, "_s_read"}, s_read, vecs[i].exp_rd);
      chk1({vecs[i].name, "_s_write"}, s_write, vecs[i].exp_wr);
      chk1({vecs[i].name, "_err"}, err, vecs[i].exp_err);
      chk1({vecs[i].name, "_m1_wait"}, m1_waitrequest, 1);
      if (vecs[i].exp_rd || vecs[i].exp_wr) begin
        chk32({vecs[i].name, "_s_addr"}, 32'(s_addr), 32'h0100 + 32'(i));
        chk1({vecs[i].name, "_owner"}, owner, 1);
      end
    end

    // m0 single write with a 3-cycle UFM stall
    do_reset();
    m0_write = 1; m0_addr = 16'h0010; m0_writedata = 32'hDEADBEEF; m0_burstcount = 1;
    s_waitrequest = 1;
    settle();
    chk1("wr_pre_s_write", s_write, 0);
    chk1("wr_pre_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      settle();
      chk1("wr_stall_s_write", s_write, 1);
      chk1("wr_stall_m0_wait", m0_waitrequest, 1);
      chk1("wr_stall_busy", busy, 1);
    end
    chk32("wr_s_addr", 32'(s_addr), 32'h0010);
    chk32("wr_s_wdata", s_writedata, 32'hDEADBEEF);
    chk1("wr_m1_wait", m1_waitrequest, 1);
    tick();
    s_waitrequest = 0;
    settle();
    chk1("wr_accept_m0_wait", m0_waitrequest, 0);
    chk1("wr_accept_busy", busy, 1);
    tick();
    m0_write = 0;
    settle();
    chk1("wr_done_busy", busy, 0);
    chk1("wr_done_s_write", s_write, 0);

    // m1 read burst of 6 with gaps; m0 write waits behind it
    do_reset();
    m1_read = 1; m1_addr = 16'h0020; m1_burstcount = 6;
    tick();
    settle();
    chk1("rd_s_read", s_read, 1);
    chk32("rd_s_burst", 32'(s_burstcount), 32'd6);
    chk32("rd_s_addr", 32'(s_addr), 32'h0020);
    chk1("rd_m1_wait", m1_waitrequest, 0);
    chk1("rd_owner", owner, 1);
    tick();
    m1_read = 0;
    m0_write = 1; m0_addr = 16'h0030; m0_burstcount = 1;
    settle();
    chk1("rd_rdata_s_read", s_read, 0);
    chk1("rd_rdata_busy", busy, 1);
    nbeats = 0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      exp_v = ((cyc % 3) != 1);
      s_readdatavalid = exp_v;
      s_readdata = 32'hA000_0000 + 32'(cyc);
      settle();
      chk1("rd_m1_rdv", m1_readdatavalid, exp_v);
      chk1("rd_m0_rdv", m0_readdatavalid, 0);
      chk1("rd_busy", busy, 1);
      chk1("rd_m0_held", s_write, 0);
      if (exp_v) chk32("rd_m1_data", m1_readdata, 32'hA000_0000 + 32'(cyc));
      if (m1_readdatavalid) nbeats++;
      tick();
    end
    s_readdatavalid = 0;
    settle();
    chk1("rd_end_busy", busy, 0);
    chk1("rd_end_s_write", s_write, 0);
    chk32("rd_beats", 32'(nbeats), 32'd6);
    tick();
    settle();
    chk1("rd_next_s_write", s_write, 1);
    chk1("rd_next_owner", owner, 0);
    tick();
    m0_write = 0;

    // Simultaneous m0 write and m1 read
    do_reset();
    m0_write = 1; m0_addr = 16'h0040; m0_burstcount = 1;
    m1_read = 1; m1_addr = 16'h0050; m1_burstcount = 1;
    for (int k = 0; k < 2; k++) begin
      who = (k == 0) ? FIRST : ~FIRST;
      tick();
      settle();
      chk1("sim_owner", owner, who);
      if (!who) begin
        chk1("sim_s_write", s_write, 1);
        chk1("sim_s_read_w", s_read, 0);
        chk32("sim_addr_w", 32'(s_addr), 32'h0040);
        tick();
        m0_write = 0;
        settle();
        chk1("sim_busy_w", busy, 0);
      end else begin
        chk1("sim_s_read", s_read, 1);
        chk1("sim_s_write_r", s_write, 0);
        chk32("sim_addr_r", 32'(s_addr), 32'h0050);
        tick();
        m1_read = 0;
        s_readdatavalid = 1; s_readdata = 32'h5555_AAAA;
        settle();
        chk1("sim_m1_rdv", m1_readdatavalid, 1);
        chk1("sim_m0_rdv", m0_readdatavalid, 0);
        tick();
        s_readdatavalid = 0;
        settle();
        chk1("sim_busy_r", busy, 0);
      end
    end

    // Illegal bursts on m1 then a legal m0 write
    do_reset();
    m1_read = 1; m1_burstcount = 0;
    tick();
    settle();
    chk1("ill0_err", err, 1);
    chk1("ill0_s_read", s_read, 0);
    chk1("ill0_m1_wait", m1_waitrequest, 1);
    chk1("ill0_busy", busy, 0);
    m1_burstcount = 9;
    tick();
    settle();
    chk1("ill9_s_read", s_read, 0);
    chk1("ill9_m1_wait", m1_waitrequest, 1);
    chk1("ill9_busy", busy, 0);
    m0_write = 1; m0_addr = 16'h0060; m0_writedata = 32'h1234_5678; m0_burstcount = 1;
    tick();
    settle();
    chk1("ill_m0_owner", owner, 0);
    chk1("ill_m0_s_write", s_write, 1);
    chk32("ill_m0_wdata", s_writedata, 32'h1234_5678);
    chk1("ill_m0_wait", m0_waitrequest, 0);
    chk1("ill_m1_wait", m1_waitrequest, 1);
    chk1("ill_s_read", s_read, 0);
    tick();
    m0_write = 0;
    settle();
    chk1("ill_m0_done_busy", busy, 0);
    chk1("ill_err_sticky", err, 1);

    // Reset after beat 3 of a 6-beat read
    do_reset();
    m1_read = 1; m1_addr = 16'h0070; m1_burstcount = 6;
    tick();
    tick();
    m1_read = 0;
    for (int b = 0; b < 3; b++) begin
      s_readdatavalid = 1; s_readdata = 32'hB000_0000 + 32'(b);
      settle();
      chk1("rab_pre_rdv", m1_readdatavalid, 1);
      tick();
    end
    s_readdatavalid = 0;
    reset = 1;
    tick();
    for (int b = 3; b < 6; b++) begin
      s_readdatavalid = 1; s_readdata = 32'hB000_0000 + 32'(b);
      settle();
      chk1("rab_late_rdv", m1_readdatavalid, 0);
      chk1("rab_busy", busy, 0);
      chk1("rab_s_read", s_read, 0);
      tick();
    end
    s_readdatavalid = 0;
    reset = 0;
    settle();
    chk1("rab_err", err, 0);
    chk1("rab_m1_wait", m1_waitrequest, 1);
    tick();
    settle();
    chk1("rab_err_after", err, 0);

    // Spurious beat in IDLE
    do_reset();
    s_readdatavalid = 1; s_readdata = 32'hCAFE_F00D;
    settle();
    chk1("spur_m0_rdv", m0_readdatavalid, 0);
    chk1("spur_m1_rdv", m1_readdatavalid, 0);
    chk32("spur_m0_rdata", m0_readdata, 32'hCAFE_F00D);
    chk32("spur_m1_rdata", m1_readdata, 32'hCAFE_F00D);
    chk1("spur_err_pre", err, 0);
    tick();
    s_readdatavalid = 0;
    settle();
    chk1("spur_err", err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
